// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM states, owner tags
// and default bus widths.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Bit positions inside the one-hot winner vector from the picker.
  localparam int WIN_IF = 0;
  localparam int WIN_D  = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational picker between fetch and data requests. Data wins ties unless
// fetch has lost STARVE_MAX arbitrations in a row.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       starve_at_max,
  output logic [1:0] win
);

  assign win[WIN_IF] = if_req && (!d_req || starve_at_max);
  assign win[WIN_D]  = d_req && !win[WIN_IF];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the fetch and load/store paths,
// one transaction outstanding, with bounded fetch starvation.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_t            state_dbg,
  output logic [3:0]        starve_cnt_dbg
);

  // Handshake: a requester holds req (address/data may change) until it sees
  // gnt in the same cycle; gnt only happens in IDLE. Exactly MEM_LAT cycles
  // later the owner gets a one-cycle rvalid; there is no back-pressure.

  localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  owner_t     owner;
  logic       we_q;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic [1:0] win;
  logic       grant;

  mem_arb_pick u_pick (
    .if_req        (if_req),
    .d_req         (d_req),
    .starve_at_max (starve_cnt == STARVE_TOP),
    .win           (win)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    // Gating on rst keeps every output quiet while reset is held.
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (|win) begin
            grant     = 1'b1;
            mem_en    = 1'b1;
            state_nxt = ST_WAIT;
            if (win[WIN_IF]) begin
              if_gnt   = 1'b1;
              mem_addr = if_addr;
            end else begin
              d_gnt     = 1'b1;
              mem_we    = d_we;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
            end
          end
        end
        ST_WAIT: begin
          busy = 1'b1;
          if (lat_cnt == LAT_LAST) begin
            state_nxt = ST_IDLE;
            if (owner == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end else begin
              d_rvalid = 1'b1;
              d_rdata  = we_q ? '0 : mem_rdata;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner   <= win[WIN_IF] ? OWN_IF : OWN_D;
        we_q    <= mem_we;
        lat_cnt <= 3'd1;
        // Only a data grant that actually blocked a waiting fetch counts as a loss.
        if (win[WIN_IF]) starve_cnt <= 4'd0;
        else if (if_req && starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 4'd1;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end

  assign state_dbg      = state;
  assign starve_cnt_dbg = starve_cnt;

endmodule
